// File: rtl/trace_sequencer_pkg.sv
// trace_sequencer_pkg: shared raybox frame/column parameters and sequencer state encoding.
package trace_sequencer_pkg;

   localparam int RB_COLS     = 640;
   localparam int RB_COL_W    = 10;
   localparam int RB_HEIGHT_W = 9;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_WRITE = 2'd3
   } state_e;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/trace_watchdog.sv
// trace_watchdog: per-column wait timer; expire_o flags the last permitted wait cycle.
module trace_watchdog #(
   parameter  int TIMEOUT = 255,
   localparam int TW      = $clog2(TIMEOUT + 1)
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic en_i,
   output logic expire_o
);

   logic [TW-1:0] timer_q;
   logic [TW-1:0] timer_d;

   assign expire_o = en_i && (timer_q == TW'(TIMEOUT - 1));
   assign timer_d  = clear_i ? '0 : (en_i && !expire_o) ? timer_q + 1'b1 : timer_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) timer_q <= '0;
      else       timer_q <= timer_d;
   end

endmodule

// File: rtl/trace_sequencer.sv
// trace_sequencer: per-frame column scheduler; issues one trace per column and writes
// the returned wall height (or FAIL_HEIGHT on timeout) into the column buffer.
module trace_sequencer
   import trace_sequencer_pkg::*;
#(
   parameter int                    COLS        = RB_COLS,
   parameter int                    COL_W       = RB_COL_W,
   parameter int                    HEIGHT_W    = RB_HEIGHT_W,
   parameter int                    TIMEOUT     = 255,
   parameter logic [HEIGHT_W-1:0]   FAIL_HEIGHT = '0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic                frame_start,
   output logic                trace_start,
   output logic [COL_W-1:0]    trace_col,
   input  logic                trace_done,
   input  logic [HEIGHT_W-1:0] trace_height,
   output logic                wr_en,
   output logic [COL_W-1:0]    wr_addr,
   output logic [HEIGHT_W-1:0] wr_data,
   output logic                busy,
   output logic                frame_done,
   output logic                overrun,
   output logic [7:0]          timeout_count
);

   state_e           state_q;
   logic [COL_W-1:0] col_q;
   logic [COL_W-1:0] col_d;
   logic             last;
   logic             expire;

   assign last  = (col_q == COL_W'(COLS - 1));
   assign col_d = last ? '0 : col_q + 1'b1;

   trace_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk      (clk),
      .reset    (reset),
      .clear_i  (state_q == ST_ISSUE),
      .en_i     (state_q == ST_WAIT),
      .expire_o (expire)
   );

   // Outputs are set on entry to the state they belong to, so each is a plain flop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         col_q         <= '0;
         trace_start   <= 1'b0;
         trace_col     <= '0;
         wr_en         <= 1'b0;
         wr_addr       <= '0;
         wr_data       <= '0;
         busy          <= 1'b0;
         frame_done    <= 1'b0;
         overrun       <= 1'b0;
         timeout_count <= '0;
      end else begin
         trace_start <= 1'b0;
         wr_en       <= 1'b0;
         frame_done  <= 1'b0;
         if (frame_start && state_q != ST_IDLE) overrun <= 1'b1;
         case (state_q)
            ST_IDLE: begin
               if (frame_start && enable) begin
                  state_q     <= ST_ISSUE;
                  col_q       <= '0;
                  trace_start <= 1'b1;
                  trace_col   <= '0;
                  busy        <= 1'b1;
               end
            end
            ST_ISSUE: state_q <= ST_WAIT;
            ST_WAIT: begin
               if (trace_done || expire) begin
                  state_q    <= ST_WRITE;
                  wr_en      <= 1'b1;
                  wr_addr    <= col_q;
                  wr_data    <= trace_done ? trace_height : FAIL_HEIGHT;
                  frame_done <= last;
                  if (!trace_done) timeout_count <= sat_inc8(timeout_count);
               end
            end
            ST_WRITE: begin
               col_q       <= col_d;
               state_q     <= last ? ST_IDLE : ST_ISSUE;
               trace_start <= !last;
               busy        <= !last;
               if (!last) trace_col <= col_d;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_trace_sequencer.sv
// tb_trace_sequencer: directed frame vectors against trace_sequencer with COLS=4, TIMEOUT=5.
module tb_trace_sequencer;

   logic       clk = 1'b0;
   logic       reset, enable, frame_start;
   logic       trace_start, trace_done, wr_en, busy, frame_done, overrun;
   logic [1:0] trace_col, wr_addr;
   logic [8:0] trace_height, wr_data;
   logic [7:0] timeout_count;

   logic       spur_done   = 1'b0;
   logic       model_done  = 1'b0;
   logic [8:0] model_h     = '0;
   logic [3:0][3:0] dly    = '0;
   int         pend        = 0;

   int checks   = 0;
   int failures = 0;
   int cyc = 0, nwr = 0, nts = 0, fd_cyc = 0;
   int wr_a[64], wr_d[64], wr_cyc[64], ts_cyc[4];
   int exp_tmo = 0;

   assign trace_done   = model_done | spur_done;
   assign trace_height = model_done ? model_h : 9'h1AB;

   always #5 clk = ~clk;

   trace_sequencer #(
      .COLS(4), .COL_W(2), .HEIGHT_W(9), .TIMEOUT(5), .FAIL_HEIGHT(9'd0)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .frame_start(frame_start),
      .trace_start(trace_start), .trace_col(trace_col), .trace_done(trace_done),
      .trace_height(trace_height), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .frame_done(frame_done), .overrun(overrun), .timeout_count(timeout_count)
   );

   // Tracer model: answers height 10+col, dly[col] cycles after trace_start (0 = never).
   always @(negedge clk) begin
      model_done = 1'b0;
      if (pend > 0) begin
         pend = pend - 1;
         if (pend == 0) model_done = 1'b1;
      end
      if (trace_start) begin
         pend    = int'(dly[trace_col]);
         model_h = 9'(10 + int'(trace_col));
      end
   end

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (trace_start) begin
         nts = nts + 1;
         ts_cyc[trace_col] = cyc;
      end
      if (wr_en) begin
         wr_a[nwr % 64]   = int'(wr_addr);
         wr_d[nwr % 64]   = int'(wr_data);
         wr_cyc[nwr % 64] = cyc;
         nwr = nwr + 1;
      end
      if (frame_done) fd_cyc = cyc;
   end

   typedef struct {
      logic [3:0][3:0] d;
      logic            spur;
      logic [3:0][8:0] h;
      int              tmo;
      int              span2;
      logic            gap;
   } vec_t;
   vec_t v[5];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic wait_done();
      logic seen = 1'b0;
      for (int k = 0; k < 200 && !seen; k++) begin
         @(negedge clk);
         seen = frame_done;
      end
      chk("frame_done seen", 32'(seen), 32'd1);
   endtask

   task automatic run_frame(input logic [3:0][3:0] d, input logic spur);
      dly = d;
      @(negedge clk);
      enable      = 1'b1;
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      spur_done   = spur;
      @(negedge clk);
      spur_done   = 1'b0;
      wait_done();
      @(negedge clk);
      chk("busy after frame", 32'(busy), 32'd0);
   endtask

   task automatic run_vec(input int i);
      int w0 = nwr;
      run_frame(v[i].d, v[i].spur);
      chk($sformatf("v%0d write count", i), 32'(nwr - w0), 32'd4);
      for (int c = 0; c < 4; c++) begin
         chk($sformatf("v%0d addr col%0d", i, c), 32'(wr_a[(w0 + c) % 64]), 32'(c));
         chk($sformatf("v%0d data col%0d", i, c), 32'(wr_d[(w0 + c) % 64]), 32'(v[i].h[c]));
      end
      exp_tmo = (exp_tmo + v[i].tmo > 255) ? 255 : exp_tmo + v[i].tmo;
      chk($sformatf("v%0d timeout_count", i), 32'(timeout_count), 32'(exp_tmo));
      chk($sformatf("v%0d frame_done cycle", i), 32'(fd_cyc), 32'(wr_cyc[(w0 + 3) % 64]));
      chk($sformatf("v%0d col2 span", i), 32'(wr_cyc[(w0 + 2) % 64] - ts_cyc[2] + 1), 32'(v[i].span2));
      if (v[i].gap)
         for (int c = 0; c < 3; c++)
            chk($sformatf("v%0d write gap %0d", i, c),
                32'(wr_cyc[(w0 + c + 1) % 64] - wr_cyc[(w0 + c) % 64]), 32'd3);
   endtask

   initial begin
      int w0, n0;
      logic seen;
      // d and h are listed col3..col0
      v[0] = '{d:{4'd1,4'd1,4'd1,4'd1}, spur:1'b0, h:{9'd13,9'd12,9'd11,9'd10}, tmo:0, span2:3, gap:1'b1};
      v[1] = '{d:{4'd1,4'd0,4'd1,4'd1}, spur:1'b0, h:{9'd13,9'd0, 9'd11,9'd10}, tmo:1, span2:7, gap:1'b0};
      v[2] = '{d:{4'd1,4'd1,4'd5,4'd1}, spur:1'b0, h:{9'd13,9'd12,9'd11,9'd10}, tmo:0, span2:3, gap:1'b0};
      v[3] = '{d:{4'd2,4'd0,4'd0,4'd3}, spur:1'b0, h:{9'd13,9'd0, 9'd0, 9'd10}, tmo:2, span2:7, gap:1'b0};
      v[4] = '{d:{4'd1,4'd1,4'd1,4'd0}, spur:1'b1, h:{9'd13,9'd12,9'd11,9'd0},  tmo:1, span2:3, gap:1'b0};

      reset = 1'b1; enable = 1'b0; frame_start = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset outputs", 32'({trace_start, trace_col, wr_en, wr_addr, wr_data, busy,
                                frame_done, overrun, timeout_count}), 32'd0);
      reset = 1'b0;

      n0 = nts;
      @(negedge clk);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      repeat (8) @(negedge clk);
      chk("disabled start traces", 32'(nts - n0), 32'd0);
      chk("disabled start busy", 32'(busy), 32'd0);
      chk("disabled start overrun", 32'(overrun), 32'd0);

      for (int i = 0; i < 5; i++) run_vec(i);

      w0 = nwr;
      spur_done = 1'b1;
      repeat (3) @(negedge clk);
      spur_done = 1'b0;
      repeat (3) @(negedge clk);
      chk("idle spurious done writes", 32'(nwr - w0), 32'd0);
      chk("overrun before test", 32'(overrun), 32'd0);

      w0 = nwr; n0 = nts; dly = 16'h1111;
      enable = 1'b1; frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      repeat (4) @(negedge clk);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      chk("overrun set", 32'(overrun), 32'd1);
      wait_done();
      repeat (20) @(negedge clk);
      chk("overrun frame writes", 32'(nwr - w0), 32'd4);
      chk("overrun frame traces", 32'(nts - n0), 32'd4);
      chk("overrun sticky", 32'(overrun), 32'd1);
      chk("overrun busy idle", 32'(busy), 32'd0);

      dly = {4'd1, 4'd1, 4'd0, 4'd1};
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 50 && !seen; k++) begin
         @(negedge clk);
         seen = trace_start && trace_col == 2'd1;
      end
      chk("col1 issue seen", 32'(seen), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("async reset outputs", 32'({trace_start, trace_col, wr_en, wr_addr, wr_data, busy,
                                      frame_done, overrun, timeout_count}), 32'd0);
      w0 = nwr;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      exp_tmo = 0;
      repeat (15) @(negedge clk);
      chk("writes after reset", 32'(nwr - w0), 32'd0);
      chk("busy after reset", 32'(busy), 32'd0);
      run_vec(0);

      for (int f = 0; f < 75; f++) begin
         run_frame(16'h0000, 1'b0);
         if (f == 62) chk("timeout_count 252", 32'(timeout_count), 32'd252);
      end
      chk("timeout_count saturated", 32'(timeout_count), 32'd255);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/trace_sequencer.md
Name: trace_sequencer

Overview:
- Per-frame column scheduler for the raybox renderer.
- On each frame-start pulse, issues one trace request per screen column to the shared column tracer (start/done handshake) and writes each returned wall height into the column-height buffer that the display path reads.
- Has a per-column watchdog timeout, overrun detection and a completion pulse. Sits between the vga_sync-derived frame timing and the tracer/column buffer.

Parameters:
- COLS, 640, number of columns traced per frame (visible width).
- COL_W, 10, width of column index; must satisfy 2^COL_W >= COLS.
- HEIGHT_W, 9, width of the wall-height result.
- TIMEOUT, 255, maximum WAIT cycles per column before giving up; must be >= 1.
- FAIL_HEIGHT, 0, height written when a column times out.

Ports:
- clk  input  1  system clock (same clock as vga_sync).
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  permits a frame-start pulse to launch a frame.
- frame_start  input  1  single-cycle pulse; start of vertical blanking.
- trace_start  output  1  single-cycle request to the tracer.
- trace_col  output  COL_W  column being traced; held stable from ISSUE through WRITE.
- trace_done  input  1  tracer result valid; sampled only in WAIT.
- trace_height  input  HEIGHT_W  tracer result, valid with trace_done.
- wr_en  output  1  column buffer write strobe.
- wr_addr  output  COL_W  column buffer write address.
- wr_data  output  HEIGHT_W  column buffer write data.
- busy  output  1  high whenever state != IDLE.
- frame_done  output  1  single-cycle pulse after the last column write.
- overrun  output  1  sticky; a frame_start arrived while busy.
- timeout_count  output  8  saturating count of timed-out columns (never clears except on reset).

Behaviour:
- Reset (async, active-high):
  - state=IDLE, col=0, timer=0.
  - Outputs cleared: trace_start, wr_en, frame_done, overrun, timeout_count, wr_addr, wr_data, trace_col all 0.
- States:
  - IDLE: if frame_start && enable -> ISSUE next cycle with col=0. frame_start with enable=0 is ignored, with no flag.
  - ISSUE: trace_start=1 for exactly this cycle; trace_col=col; timer<=0; -> WAIT.
  - WAIT:
    - If trace_done: capture trace_height, -> WRITE.
    - Else if timer==TIMEOUT-1: capture FAIL_HEIGHT; timeout_count<=sat(timeout_count+1), saturating at 255; -> WRITE.
    - Else timer++.
    - trace_done takes priority over timeout in the same cycle.
  - WRITE: wr_en=1, wr_addr=col, wr_data=captured height, all for this one cycle.
    - If col==COLS-1: frame_done=1 this cycle, col<=0, -> IDLE.
    - Else col<=col+1, -> ISSUE.
- Timing:
  - trace_done asserted during ISSUE or IDLE is ignored and not remembered.
  - Minimum 3 cycles per column (ISSUE, WAIT with done, WRITE); full frame minimum 3*COLS cycles.
  - Maximum per column is 2+TIMEOUT cycles.
- Registered outputs: all outputs are registered (state-decoded from flops); no combinational input-to-output path.
- Overrun:
  - frame_start in any non-IDLE state (including the final WRITE cycle) sets overrun=1 and is otherwise ignored.
  - The current frame continues undisturbed.
- Enable: deassertion mid-frame does not abort the frame; it only gates new launches.
- Reset mid-frame: immediately returns to IDLE. No further wr_en is issued; partial buffer contents are left as written.
- Width rules:
  - col compares against COLS-1 at COL_W bits; no wrap beyond COLS-1.
  - timer is ceil(log2(TIMEOUT+1)) bits.

Decomposition:
- Shared raybox params header: COLS, COL_W, HEIGHT_W, state encoding localparams (IDLE/ISSUE/WAIT/WRITE), also used by the tracer and column buffer.
- One natural sub-module, trace_watchdog: timer with clear, enable and expire output, parameterised by TIMEOUT.
- The FSM, column counter and statistics stay in trace_sequencer.

Test Plan:
- Basic frame: COLS=4; tracer returns height=10+col exactly 1 cycle after trace_start.
  - Expect writes (0,10),(1,11),(2,12),(3,13), each 3 cycles apart.
  - frame_done in the cycle of the col-3 write; busy low the next cycle.
- Timeout: TIMEOUT=5; tracer never responds for col 2.
  - col 2 WRITE occurs 7 cycles after its ISSUE cycle, with wr_data=FAIL_HEIGHT=0.
  - timeout_count=1; remaining columns proceed normally.
- Done/timeout collision: trace_done in the cycle timer==TIMEOUT-1 -> traced height written; timeout_count unchanged.
- Overrun and enable:
  - frame_start mid-frame -> overrun=1 sticky; the frame still completes with exactly COLS writes; no second frame launched.
  - frame_start with enable=0 in IDLE -> no trace_start, overrun stays 0.
- Reset mid-frame: assert reset during col-1 WAIT.
  - All outputs 0 asynchronously; no wr_en after reset.
  - The next frame_start begins again at col=0.
- Spurious done and saturation:
  - trace_done pulses in IDLE/ISSUE -> no writes.
  - 300 forced timeouts -> timeout_count holds at 255.
